uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Parametrised command controller placed between a uart_rx and a uart_tx instance.
- Parses 2-byte frames (command, argument) from the RX byte stream and updates an LED/status register.
- Queues one response byte per frame in a small FIFO and drains the FIFO to the TX handshake.
- Generalises the fixed single-code LED match into a programmable, acknowledged protocol with timeout and buffering.

Parameters:
DATA_W, 8, UART byte width
LED_W, 3, LED/status register width (LED_W <= DATA_W)
FIFO_DEPTH, 4, response FIFO entries (power of 2, >= 2)
TIMEOUT_CYC, 100000, max clocks between cmd byte and arg byte
CMD_SET, 8'hCA, led <= arg
CMD_OR, 8'hCB, led <= led | arg
CMD_READ, 8'hCC, respond with led value
CMD_ECHO, 8'hCD, respond with arg
ACK_BYTE, 8'h06, success response
NAK_BYTE, 8'h15, error response

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous, active-low reset
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid
i_Rx_Byte  in  DATA_W  received byte
i_Tx_Active  in  1  transmitter busy
i_Tx_Done  in  1  one-cycle strobe: byte fully sent
o_Tx_DV  out  1  one-cycle strobe: start transmit of o_Tx_Byte
o_Tx_Byte  out  DATA_W  byte to transmit, held stable until i_Tx_Done
o_Led  out  LED_W  LED/status register
o_Busy  out  1  parser not in IDLE
o_Overflow  out  1  sticky: a response was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): o_Led=0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Overflow=0, FIFO empty, parser IDLE, TX IDLE, timeout counter 0.
- Parser FSM:
  - IDLE:
    - On i_Rx_DV with a known command code: latch the command, clear the timer, go to WAIT_ARG.
    - On i_Rx_DV with an unknown code: push NAK_BYTE and stay in IDLE.
  - WAIT_ARG:
    - Timer increments each cycle.
    - On i_Rx_DV: execute at the next edge, then go to IDLE.
      - SET: led <= arg[LED_W-1:0], push ACK.
      - OR: led <= led | arg[LED_W-1:0], push ACK.
      - READ: push the led value zero-extended to DATA_W; arg is ignored.
      - ECHO: push arg.
    - When the timer reaches TIMEOUT_CYC-1 with no i_Rx_DV: push NAK, go to IDLE, leave led unchanged.
    - If i_Rx_DV and timeout coincide, i_Rx_DV wins and the command executes.
- Latency: o_Led and the FIFO push take effect on the edge that samples the arg's i_Rx_DV.
- o_Busy = (state != IDLE).
- FIFO rules:
  - Push when full: the byte is discarded and o_Overflow is set until reset.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH; the count width is clog2(FIFO_DEPTH)+1.
- TX FSM:
  - TX_IDLE: if the FIFO is non-empty and !i_Tx_Active, pop the head into o_Tx_Byte, pulse o_Tx_DV for 1 cycle, go to TX_WAIT.
  - TX_WAIT: on i_Tx_Done, return to TX_IDLE. At most one byte is in flight.
  - Back-to-back responses are therefore separated by at least 1 idle cycle after i_Tx_Done.
- Reset mid-frame or mid-transmit: all state clears immediately; a partially sent byte is abandoned.

Optional Feature:
- Macro UART_CMD_CHECKSUM_EN.
- Defined: frames are 3 bytes (cmd, arg, chk) with an extra WAIT_CHK state and the same timeout rule.
  - Execute only if chk == cmd ^ arg; otherwise push NAK and leave led unchanged.
  - The timer restarts on entry to WAIT_CHK.
- Undefined: 2-byte frames as above; no WAIT_CHK state is built.

Decomposition:
- Package uart_cmd_pkg holds:
  - default command codes, ACK/NAK values;
  - parser state enum (IDLE, WAIT_ARG, WAIT_CHK);
  - TX state enum (TX_IDLE, TX_WAIT).
- Sub-module byte_fifo: synchronous FIFO, parameters DATA_W/FIFO_DEPTH, ports push/pop/full/empty/count, same clock and reset.

Test Plan:
- Send CA,05 -> o_Led=3'b101 one edge after the second i_Rx_DV; o_Tx_DV pulses with o_Tx_Byte=06.
- Send CA,01 then CB,04 then CC,00 -> o_Led=3'b101; TX bytes 06,06,05 in order, each o_Tx_DV only after the prior i_Tx_Done.
- Send 7E -> TX byte 15; parser stays IDLE (o_Busy never asserts); o_Led unchanged.
- Send CA, then no byte for TIMEOUT_CYC (param set to 16) -> NAK at cycle 16; o_Busy drops; a following CD,3C echoes 3C.
- Hold i_Tx_Active=1 and send 5 ECHO frames (FIFO_DEPTH=4) -> 4 queued; o_Overflow=1; after release TX outputs the first 4 args.
- Assert i_Rst_n=0 in WAIT_ARG and in TX_WAIT -> all outputs 0 immediately; a fresh CA,02 works normally after release.
- With UART_CMD_CHECKSUM_EN: CA,03,C9 -> led=3 with ACK; CA,03,00 -> NAK with led unchanged.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared command codes, response bytes and FSM state encodings for uart_cmd_ctrl.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_SET_DEF  = 8'hCA;
    localparam logic [7:0] CMD_OR_DEF   = 8'hCB;
    localparam logic [7:0] CMD_READ_DEF = 8'hCC;
    localparam logic [7:0] CMD_ECHO_DEF = 8'hCD;
    localparam logic [7:0] ACK_DEF      = 8'h06;
    localparam logic [7:0] NAK_DEF      = 8'h15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ARG = 2'd1,
        WAIT_CHK = 2'd2
    } parse_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO, combinational head read; push/pop land on the same edge.
// A push while full is dropped unless a pop in that cycle frees the slot.
module byte_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_dat,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_dat,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_en, rd_en;

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: cmd/arg frames update o_Led and queue one response byte, which is drained to TX one byte in flight.
// Effects land on the edge sampling the arg byte; i_Tx_Active stalls the drain, and a full FIFO drops responses (sticky o_Overflow). UART_CMD_CHECKSUM_EN adds a checksum byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                LED_W       = 3,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                TIMEOUT_CYC = 100000,
    parameter logic [DATA_W-1:0] CMD_SET     = DATA_W'(CMD_SET_DEF),
    parameter logic [DATA_W-1:0] CMD_OR      = DATA_W'(CMD_OR_DEF),
    parameter logic [DATA_W-1:0] CMD_READ    = DATA_W'(CMD_READ_DEF),
    parameter logic [DATA_W-1:0] CMD_ECHO    = DATA_W'(CMD_ECHO_DEF),
    parameter logic [DATA_W-1:0] ACK_BYTE    = DATA_W'(ACK_DEF),
    parameter logic [DATA_W-1:0] NAK_BYTE    = DATA_W'(NAK_DEF)
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_DV,
    input  logic [DATA_W-1:0] i_Rx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Tx_DV,
    output logic [DATA_W-1:0] o_Tx_Byte,
    output logic [LED_W-1:0]  o_Led,
    output logic              o_Busy,
    output logic              o_Overflow
);
    localparam int              TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    parse_state_e      state_q, state_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              ovf_q, ovf_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [DATA_W-1:0] arg_q, arg_d;
`endif

    logic              push, pop;
    logic [DATA_W-1:0] push_dat, fifo_rdat;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    logic [DATA_W-1:0] exec_arg;
    logic [LED_W-1:0]  exec_led;
    logic [DATA_W-1:0] exec_rsp;

    function automatic logic is_cmd(input logic [DATA_W-1:0] b);
        return (b == CMD_SET) || (b == CMD_OR) || (b == CMD_READ) || (b == CMD_ECHO);
    endfunction

`ifdef UART_CMD_CHECKSUM_EN
    assign exec_arg = arg_q;
`else
    assign exec_arg = i_Rx_Byte;
`endif

    // Result of executing the latched command against exec_arg.
    always_comb begin
        exec_led = led_q;
        exec_rsp = ACK_BYTE;
        case (cmd_q)
            CMD_SET:  exec_led = exec_arg[LED_W-1:0];
            CMD_OR:   exec_led = led_q | exec_arg[LED_W-1:0];
            CMD_READ: exec_rsp = DATA_W'(led_q);
            CMD_ECHO: exec_rsp = exec_arg;
            default:  exec_rsp = NAK_BYTE;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        timer_d  = timer_q;
        led_d    = led_q;
        push     = 1'b0;
        push_dat = ACK_BYTE;
`ifdef UART_CMD_CHECKSUM_EN
        arg_d    = arg_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Rx_DV) begin
                    if (is_cmd(i_Rx_Byte)) begin
                        cmd_d   = i_Rx_Byte;
                        timer_d = '0;
                        state_d = WAIT_ARG;
                    end else begin
                        push     = 1'b1;
                        push_dat = NAK_BYTE;
                    end
                end
            end
            WAIT_ARG: begin
                timer_d = timer_q + TMR_W'(1);
                // A byte arriving on the timeout cycle still counts.
                if (i_Rx_DV) begin
`ifdef UART_CMD_CHECKSUM_EN
                    arg_d   = i_Rx_Byte;
                    timer_d = '0;
                    state_d = WAIT_CHK;
`else
                    led_d    = exec_led;
                    push     = 1'b1;
                    push_dat = exec_rsp;
                    state_d  = IDLE;
`endif
                end else if (timer_q == TMR_LAST) begin
                    push     = 1'b1;
                    push_dat = NAK_BYTE;
                    state_d  = IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            WAIT_CHK: begin
                timer_d = timer_q + TMR_W'(1);
                if (i_Rx_DV) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    if (i_Rx_Byte == (cmd_q ^ arg_q)) begin
                        led_d    = exec_led;
                        push_dat = exec_rsp;
                    end else begin
                        push_dat = NAK_BYTE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    push     = 1'b1;
                    push_dat = NAK_BYTE;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty && !i_Tx_Active) begin
                    pop        = 1'b1;
                    tx_byte_d  = fifo_rdat;
                    tx_dv_d    = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (i_Tx_Done) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Drop is only real when no same-cycle pop makes room.
    assign ovf_d = ovf_q | (push & fifo_full & ~pop);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            timer_q    <= '0;
            led_q      <= '0;
            ovf_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            arg_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            timer_q    <= timer_d;
            led_q      <= led_d;
            ovf_q      <= ovf_d;
            tx_state_q <= tx_state_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
`ifdef UART_CMD_CHECKSUM_EN
            arg_q      <= arg_d;
`endif
        end
    end

    byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_Clock  (i_Clock),
        .i_Rst_n  (i_Rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (fifo_rdat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    fifo_cnt_bound: assert property (@(posedge i_Clock) disable iff (!i_Rst_n)
        fifo_cnt <= CNT_W'(FIFO_DEPTH));

    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Led      = led_q;
    assign o_Busy     = (state_q != IDLE);
    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a simple uart_tx responder model.
module tb_uart_cmd_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_done = 1'b0;
    logic       hold    = 1'b0;
    logic       resp_busy = 1'b0;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [2:0] led;
    logic       busy;
    logic       ovf;

    int         resp_cnt = 0;
    int         viol = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] rxq[$];
    logic [7:0] got;

    typedef struct {
        logic       single;
        logic [7:0] cmd;
        logic [7:0] arg;
        logic [2:0] led;
        logic [7:0] rsp;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    assign tx_active = resp_busy | hold;

    uart_cmd_ctrl #(
        .DATA_W      (8),
        .LED_W       (3),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .o_Led       (led),
        .o_Busy      (busy),
        .o_Overflow  (ovf)
    );

    // Transmitter model: captures each started byte, busy for a few cycles, then pulses done.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_busy = 1'b0;
            resp_cnt  = 0;
            tx_done   = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_dv) begin
                if (resp_busy) viol++;
                rxq.push_back(tx_byte);
                resp_busy = 1'b1;
                resp_cnt  = 3;
            end else if (resp_busy) begin
                if (resp_cnt == 0) begin
                    tx_done   = 1'b1;
                    resp_busy = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
        send_byte(c);
        send_byte(a);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(c ^ a);
`endif
    endtask

    task automatic wait_tx(output logic [7:0] b);
        b = 8'hxx;
        for (int i = 0; i < 300; i++) begin
            if (rxq.size() > 0) begin
                b = rxq.pop_front();
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'hCA, 8'h05, 3'd5, 8'h06};
        vecs[1] = '{1'b0, 8'hCA, 8'h01, 3'd1, 8'h06};
        vecs[2] = '{1'b0, 8'hCB, 8'h04, 3'd5, 8'h06};
        vecs[3] = '{1'b0, 8'hCC, 8'h00, 3'd5, 8'h05};
        vecs[4] = '{1'b0, 8'hCD, 8'h3C, 3'd5, 8'h3C};
        vecs[5] = '{1'b1, 8'h7E, 8'h00, 3'd5, 8'h15};
        vecs[6] = '{1'b0, 8'hCB, 8'h02, 3'd7, 8'h06};
        vecs[7] = '{1'b0, 8'hCC, 8'hFF, 3'd7, 8'h07};
        vecs[8] = '{1'b0, 8'hCA, 8'hF8, 3'd0, 8'h06};
        vecs[9] = '{1'b0, 8'hCD, 8'hA5, 3'd0, 8'hA5};

        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].single) begin
                send_byte(vecs[i].cmd);
                chk($sformatf("v%0d_busy_unknown", i), busy, 0);
            end else begin
                send_byte(vecs[i].cmd);
                chk($sformatf("v%0d_busy_cmd", i), busy, 1);
                send_byte(vecs[i].arg);
`ifdef UART_CMD_CHECKSUM_EN
                send_byte(vecs[i].cmd ^ vecs[i].arg);
`endif
            end
            chk($sformatf("v%0d_led", i), led, vecs[i].led);
            chk($sformatf("v%0d_idle", i), busy, 0);
            wait_tx(got);
            chk($sformatf("v%0d_rsp", i), got, vecs[i].rsp);
        end

        // Timeout: NAK on the 16th edge after the command byte.
        send_byte(8'hCA);
        chk("to_busy_start", busy, 1);
        repeat (15) @(negedge clk);
        chk("to_busy_edge15", busy, 1);
        @(negedge clk);
        chk("to_busy_edge16", busy, 0);
        wait_tx(got);
        chk("to_nak", got, 8'h15);
        chk("to_led_kept", led, 0);
        send_frame(8'hCD, 8'h3C);
        wait_tx(got);
        chk("to_echo_after", got, 8'h3C);

        // Arg byte arriving on the timeout cycle wins.
        send_byte(8'hCA);
        repeat (15) @(negedge clk);
        send_byte(8'h06);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hCC);
`endif
        chk("coin_led", led, 6);
        wait_tx(got);
        chk("coin_ack", got, 8'h06);

        // Overflow: 5 responses into a 4-deep FIFO while TX is held busy.
        repeat (10) @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_before_5th", ovf, 0);
            send_frame(8'hCD, 8'(8'h11 * (i + 1)));
        end
        chk("ovf_set", ovf, 1);
        repeat (5) @(negedge clk);
        chk("ovf_no_tx_held", rxq.size(), 0);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tx(got);
            chk($sformatf("ovf_drain%0d", i), got, 8'(8'h11 * (i + 1)));
        end
        repeat (50) @(negedge clk);
        chk("ovf_no_5th", rxq.size(), 0);
        chk("ovf_sticky", ovf, 1);

        // Reset in WAIT_ARG.
        send_byte(8'hCA);
        chk("rwa_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rwa_busy", busy, 0);
        chk("rwa_led", led, 0);
        chk("rwa_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'hCA, 8'h02);
        chk("rwa_led_after", led, 2);
        wait_tx(got);
        chk("rwa_ack_after", got, 8'h06);

        // Reset in TX_WAIT.
        repeat (10) @(negedge clk);
        send_frame(8'hCD, 8'h77);
        wait_tx(got);
        chk("rtw_echo", got, 8'h77);
        chk("rtw_byte_before", tx_byte, 8'h77);
        rst_n = 1'b0;
        #1;
        chk("rtw_tx_byte", tx_byte, 0);
        chk("rtw_tx_dv", tx_dv, 0);
        chk("rtw_led", led, 0);
        chk("rtw_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rxq.delete();
        @(negedge clk);
        send_frame(8'hCA, 8'h02);
        chk("rtw_led_after", led, 2);
        wait_tx(got);
        chk("rtw_ack_after", got, 8'h06);

`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hCA);
        send_byte(8'h03);
        send_byte(8'h00);
        chk("cks_bad_led", led, 2);
        wait_tx(got);
        chk("cks_bad_nak", got, 8'h15);
        send_byte(8'hCA);
        send_byte(8'h03);
        send_byte(8'hC9);
        chk("cks_good_led", led, 3);
        wait_tx(got);
        chk("cks_good_ack", got, 8'h06);
`endif

        repeat (10) @(negedge clk);
        chk("tx_dv_while_busy", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
